// File: rtl/risc16_pkg.sv
// Shared encodings for the RiSC-16 control path: opcodes, sequencer states and
// the select codes driven to the PC mux, ALU and register-file write port.
package risc16_pkg;

  // Opcode field instr[15:13]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  // PC mux select, shared with the PC register
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;  // PC+1
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;  // PC+imm+1
  localparam logic [1:0] PC_SEL_JALR   = 2'b10;  // alu_out

  // ALU operation
  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_NAND = 2'b01;
  localparam logic [1:0] ALU_OP_PASS = 2'b10;
  localparam logic [1:0] ALU_OP_SUB  = 2'b11;

  // Register-file write data select
  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_LUI = 2'b10;
  localparam logic [1:0] WSEL_PC1 = 2'b11;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalted,
    StError
  } state_e;

  // HALT is JALR with a non-zero low field
  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[15:13] == OP_JALR) && (instr[6:0] != 7'd0);
  endfunction

endpackage

// File: rtl/risc16_ack_timer.sv
// Memory-ack watchdog: counts consecutive cycles a request waits without ack and
// flags expiry on the cycle the count would reach ACK_TIMEOUT. ACK_TIMEOUT=0
// removes the counter entirely.
module risc16_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  if (ACK_TIMEOUT == 0) begin : g_off
    logic w_unused;
    assign w_unused = ^{clk, rst_n, i_clr, i_inc};
    assign o_expire = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(ACK_TIMEOUT - 1);

    logic [CntW-1:0] r_cnt;

    // Wait-cycle counter; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (i_clr) begin
        r_cnt <= '0;
      end else if (i_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // This waiting cycle is the ACK_TIMEOUT-th one
    assign o_expire = i_inc && (r_cnt == LastCnt);
  end

endmodule

// File: rtl/risc16_ctrl_fsm.sv
// Multi-cycle control sequencer for the RiSC-16 core. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives PC, ALU, register-file and memory
// handshake controls, and parks in HALTED or ERROR until reset.
module risc16_ctrl_fsm
  import risc16_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_instr,
  input  logic        i_alu_zero,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_dsel,
  output logic        o_ir_load,
  output logic [1:0]  o_alu_op,
  output logic        o_alu_src_imm,
  output logic        o_rf_we,
  output logic [1:0]  o_rf_wsel,
  output logic [1:0]  o_pc_sel,
  output logic        o_pc_en,
  output logic        o_halted,
  output logic        o_err
);

  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] w_opcode;
  logic       w_is_sw;
  logic       w_waiting;
  logic       w_wd_clr;
  logic       w_wd_inc;
  logic       w_wd_expire;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_mem_dsel;
  logic       w_ir_load;
  logic [1:0] w_alu_op;
  logic       w_alu_src_imm;
  logic       w_rf_we;
  logic [1:0] w_rf_wsel;
  logic [1:0] w_pc_sel;
  logic       w_pc_en;
  logic       w_halted;
  logic       w_err;

  assign w_opcode = i_instr[15:13];
  assign w_is_sw  = (w_opcode == OP_SW);

  // Watchdog is driven from the current state only, keeping it off the next-state path.
  // Every FETCH/MEM visit ends with an ack, so clearing on any non-waiting cycle means
  // each new request starts counting from zero.
  assign w_waiting = (r_state == StFetch) || (r_state == StMem);
  assign w_wd_inc  = w_waiting && !i_mem_ack;
  assign w_wd_clr  = !w_wd_inc;

  risc16_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_wd_clr),
    .i_inc   (w_wd_inc),
    .o_expire(w_wd_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_next  = r_state;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_dsel    = 1'b0;
    w_ir_load     = 1'b0;
    w_alu_op      = ALU_OP_ADD;
    w_alu_src_imm = 1'b0;
    w_rf_we       = 1'b0;
    w_rf_wsel     = WSEL_ALU;
    w_pc_sel      = PC_SEL_SEQ;
    w_pc_en       = 1'b0;
    w_halted      = 1'b0;
    w_err         = 1'b0;

    unique case (r_state)
      StFetch: begin
        w_mem_req = 1'b1;
        if (i_mem_ack) begin
          w_ir_load    = 1'b1;
          w_state_next = StDecode;
        end else if (w_wd_expire) begin
          w_state_next = StError;
        end
      end

      StDecode: begin
        w_state_next = is_halt(i_instr) ? StHalted : StExec;
      end

      StExec: begin
        w_state_next = StFetch;
        unique case (w_opcode)
          OP_ADD: begin
            w_rf_we = 1'b1;
            w_pc_en = 1'b1;
          end
          OP_ADDI: begin
            w_alu_src_imm = 1'b1;
            w_rf_we       = 1'b1;
            w_pc_en       = 1'b1;
          end
          OP_NAND: begin
            w_alu_op = ALU_OP_NAND;
            w_rf_we  = 1'b1;
            w_pc_en  = 1'b1;
          end
          OP_LUI: begin
            w_alu_op  = ALU_OP_PASS;
            w_rf_we   = 1'b1;
            w_rf_wsel = WSEL_LUI;
            w_pc_en   = 1'b1;
          end
          OP_SW, OP_LW: begin
            // Address = regB + imm7, held through MEM
            w_alu_src_imm = 1'b1;
            w_state_next  = StMem;
          end
          OP_BEQ: begin
            w_alu_op = ALU_OP_SUB;
            w_pc_en  = 1'b1;
            w_pc_sel = i_alu_zero ? PC_SEL_BRANCH : PC_SEL_SEQ;
          end
          OP_JALR: begin
            w_rf_we   = 1'b1;
            w_rf_wsel = WSEL_PC1;
            w_pc_en   = 1'b1;
            w_pc_sel  = PC_SEL_JALR;
          end
          default: ;
        endcase
      end

      StMem: begin
        w_mem_req     = 1'b1;
        w_mem_dsel    = 1'b1;
        w_mem_we      = w_is_sw;
        w_alu_src_imm = 1'b1;
        if (i_mem_ack) begin
          if (w_is_sw) begin
            w_pc_en      = 1'b1;
            w_state_next = StFetch;
          end else begin
            w_state_next = StWb;
          end
        end else if (w_wd_expire) begin
          w_state_next = StError;
        end
      end

      StWb: begin
        w_rf_we      = 1'b1;
        w_rf_wsel    = WSEL_MEM;
        w_pc_en      = 1'b1;
        w_state_next = StFetch;
      end

      StHalted: w_halted = 1'b1;

      StError: w_err = 1'b1;

      default: w_state_next = StFetch;
    endcase
  end

  // Outputs forced low while reset is asserted, so a pending request drops at once
  assign o_mem_req     = rst_n & w_mem_req;
  assign o_mem_we      = rst_n & w_mem_we;
  assign o_mem_dsel    = rst_n & w_mem_dsel;
  assign o_ir_load     = rst_n & w_ir_load;
  assign o_alu_op      = rst_n ? w_alu_op : 2'b00;
  assign o_alu_src_imm = rst_n & w_alu_src_imm;
  assign o_rf_we       = rst_n & w_rf_we;
  assign o_rf_wsel     = rst_n ? w_rf_wsel : 2'b00;
  assign o_pc_sel      = rst_n ? w_pc_sel : 2'b00;
  assign o_pc_en       = rst_n & w_pc_en;
  assign o_halted      = rst_n & w_halted;
  assign o_err         = rst_n & w_err;

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// Self-checking bench for risc16_ctrl_fsm: directed instruction sequences with a
// per-cycle expectation built from the instruction's phase list, plus literal pins.
module tb_risc16_ctrl_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_dsel;
    logic       ir_load;
    logic [1:0] alu_op;
    logic       alu_src_imm;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic [1:0] pc_sel;
    logic       pc_en;
    logic       halted;
    logic       err;
  } outs_t;

  typedef enum {PhReset, PhFetch, PhDecode, PhExec, PhMem, PhWb, PhHalt, PhErr} phase_e;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_instr;
  logic        i_alu_zero;
  logic        i_mem_ack;
  logic        o_mem_req, o_mem_we, o_mem_dsel, o_ir_load, o_alu_src_imm, o_rf_we;
  logic        o_pc_en, o_halted, o_err;
  logic [1:0]  o_alu_op, o_rf_wsel, o_pc_sel;

  outs_t  dut_outs;
  outs_t  exp_outs;
  phase_e cur_ph;
  logic   chk_en;
  int     checks;
  int     failures;
  outs_t  trace [0:31];
  int     trace_n;

  risc16_ctrl_fsm #(
    .ACK_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_instr      (i_instr),
    .i_alu_zero   (i_alu_zero),
    .i_mem_ack    (i_mem_ack),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_dsel   (o_mem_dsel),
    .o_ir_load    (o_ir_load),
    .o_alu_op     (o_alu_op),
    .o_alu_src_imm(o_alu_src_imm),
    .o_rf_we      (o_rf_we),
    .o_rf_wsel    (o_rf_wsel),
    .o_pc_sel     (o_pc_sel),
    .o_pc_en      (o_pc_en),
    .o_halted     (o_halted),
    .o_err        (o_err)
  );

  assign dut_outs = {o_mem_req, o_mem_we, o_mem_dsel, o_ir_load, o_alu_op, o_alu_src_imm,
                     o_rf_we, o_rf_wsel, o_pc_sel, o_pc_en, o_halted, o_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the controls must be in a given phase of an instruction
  function automatic outs_t model(input phase_e ph, input logic [15:0] ins, input logic zero,
                                  input logic ack);
    outs_t o;
    logic [2:0] op;
    o  = '0;
    op = ins[15:13];
    case (ph)
      PhFetch: begin
        o.mem_req = 1'b1;
        o.ir_load = ack;
      end
      PhExec: begin
        case (op)
          3'd0: begin o.rf_we = 1'b1; o.pc_en = 1'b1; end
          3'd1: begin o.alu_src_imm = 1'b1; o.rf_we = 1'b1; o.pc_en = 1'b1; end
          3'd2: begin o.alu_op = 2'b01; o.rf_we = 1'b1; o.pc_en = 1'b1; end
          3'd3: begin o.alu_op = 2'b10; o.rf_we = 1'b1; o.rf_wsel = 2'b10; o.pc_en = 1'b1; end
          3'd4, 3'd5: o.alu_src_imm = 1'b1;
          3'd6: begin o.alu_op = 2'b11; o.pc_en = 1'b1; o.pc_sel = zero ? 2'b01 : 2'b00; end
          default: begin o.rf_we = 1'b1; o.rf_wsel = 2'b11; o.pc_sel = 2'b10; o.pc_en = 1'b1; end
        endcase
      end
      PhMem: begin
        o.mem_req     = 1'b1;
        o.mem_dsel    = 1'b1;
        o.mem_we      = (op == 3'd4);
        o.alu_src_imm = 1'b1;
        o.pc_en       = (op == 3'd4) && ack;
      end
      PhWb: begin
        o.rf_we   = 1'b1;
        o.rf_wsel = 2'b01;
        o.pc_en   = 1'b1;
      end
      PhHalt: o.halted = 1'b1;
      PhErr:  o.err = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checks++;
        if (dut_outs !== exp_outs) begin
          failures++;
          $display("FAIL cycle %s t=%0t: got %h required %h", cur_ph.name(), $time, dut_outs,
                   exp_outs);
        end
      end
    end
  end

  // Literal pin on a captured trace field
  task automatic pin(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL pin %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // One clock cycle in phase ph; called just after a rising edge
  task automatic step(input phase_e ph, input logic ack);
    i_mem_ack = ack;
    cur_ph    = ph;
    exp_outs  = (ph == PhReset) ? '0 : model(ph, i_instr, i_alu_zero, ack);
    @(negedge clk);
    if (trace_n < 32) trace[trace_n] = dut_outs;
    trace_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic zero, input int fw, input int mw,
                           input logic noise);
    logic [2:0] op;
    op         = ins[15:13];
    trace_n    = 0;
    i_instr    = ins;
    i_alu_zero = zero;
    for (int i = 0; i <= fw; i++) step(PhFetch, i == fw);
    step(PhDecode, noise);
    if (op == 3'd7 && ins[6:0] != 7'd0) begin
      for (int i = 0; i < 3; i++) step(PhHalt, i[0]);
    end else begin
      step(PhExec, noise);
      if (op == 3'd4 || op == 3'd5) begin
        for (int i = 0; i <= mw; i++) step(PhMem, i == mw);
        if (op == 3'd5) step(PhWb, noise);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(PhReset, 1'b0);
    step(PhReset, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    trace_n    = 0;
    rst_n      = 1'b0;
    i_instr    = 16'h0000;
    i_alu_zero = 1'b0;
    i_mem_ack  = 1'b0;
    exp_outs   = '0;
    cur_ph     = PhReset;
    chk_en     = 1'b1;
    #1;
    do_reset();

    // ADDI, zero-wait memory
    run_instr(16'h2481, 1'b0, 0, 0, 1'b0);
    pin("addi_irload_c1", int'(trace[0].ir_load), 1);
    pin("addi_decode_idle", int'(trace[1]), 0);
    pin("addi_rfwe_pcen_c3", int'(trace[2].rf_we & trace[2].pc_en), 1);
    pin("addi_pcsel_c3", int'(trace[2].pc_sel), 0);
    pin("addi_srcimm_c3", int'(trace[2].alu_src_imm), 1);

    run_instr(16'h0483, 1'b1, 1, 0, 1'b1);  // ADD, one fetch wait, stray acks
    run_instr(16'h4483, 1'b0, 0, 0, 1'b0);  // NAND
    run_instr(16'h6555, 1'b0, 2, 0, 1'b1);  // LUI

    // BEQ taken / not taken
    run_instr(16'hC07F, 1'b1, 0, 0, 1'b0);
    pin("beq_taken_pcsel", int'(trace[2].pc_sel), 1);
    pin("beq_taken_pcen", int'(trace[2].pc_en), 1);
    run_instr(16'hC07F, 1'b0, 0, 0, 1'b1);
    pin("beq_nt_pcsel", int'(trace[2].pc_sel), 0);
    pin("beq_nt_aluop", int'(trace[2].alu_op), 3);

    // LW with ack on the third MEM cycle
    run_instr(16'hA485, 1'b0, 0, 2, 1'b1);
    pin("lw_req_held", int'(trace[3].mem_req & trace[4].mem_req & trace[5].mem_req), 1);
    pin("lw_dsel", int'(trace[4].mem_dsel), 1);
    pin("lw_we", int'(trace[5].mem_we), 0);
    pin("lw_wb", int'({trace[6].rf_we, trace[6].rf_wsel, trace[6].pc_en}), 4'b1011);
    pin("lw_len", trace_n, 7);

    // SW zero-wait, then SW and LW acked on the last permissible waiting cycle
    run_instr(16'h8485, 1'b0, 0, 0, 1'b0);
    pin("sw_mem_pcen", int'({trace[3].mem_we, trace[3].pc_en}), 3);
    run_instr(16'h8485, 1'b0, 3, 3, 1'b1);
    run_instr(16'hA485, 1'b1, 3, 3, 1'b0);

    // JALR
    run_instr(16'hE080, 1'b0, 0, 0, 1'b1);
    pin("jalr_ctrl", int'({trace[2].rf_we, trace[2].rf_wsel, trace[2].pc_sel}), 5'b11110);

    // HALT: sticky, no memory traffic
    run_instr(16'hE001, 1'b0, 0, 0, 1'b1);
    pin("halt_c3", int'(trace[2].halted), 1);
    pin("halt_noreq", int'(trace[3].mem_req), 0);
    do_reset();

    // Fetch ack never arrives
    trace_n = 0;
    i_instr = 16'h0000;
    for (int i = 0; i < 4; i++) step(PhFetch, 1'b0);
    step(PhErr, 1'b0);
    step(PhErr, 1'b1);
    step(PhErr, 1'b0);
    pin("wd_req_c4", int'({trace[3].mem_req, trace[3].err}), 2);
    pin("wd_err_c5", int'({trace[4].mem_req, trace[4].err}), 1);
    pin("wd_sticky", int'(trace[6].err), 1);
    do_reset();

    // Reset in the middle of a LW memory wait
    trace_n = 0;
    i_instr = 16'hA485;
    step(PhFetch, 1'b1);
    step(PhDecode, 1'b0);
    step(PhExec, 1'b0);
    step(PhMem, 1'b0);
    rst_n = 1'b0;
    step(PhReset, 1'b1);
    pin("midmem_req_drop", int'(trace[4].mem_req), 0);
    rst_n = 1'b1;
    run_instr(16'h0483, 1'b0, 0, 0, 1'b0);
    pin("restart_fetch", int'(trace[0].mem_req & trace[0].ir_load), 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
